fetch_queue: RTL and testbench

Parametrised instruction prefetch queue between instruction memory and the decode unit. Fetches sequential words from a local fetch PC into a FIFO of `DEPTH` entries, tagging each word with its address. Supports PC redirect with flush and a halt/resume state machine. Presents a valid/take handshake to decode, replacing the single-register fetch stage.

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 tb/tb_fetch_queue.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between imem and decode.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass.
module fetch_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_rdy,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_adr,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_adr,
    input  logic                    halt,
    input  logic                    resume,
    output logic                    o_rdy,
    output logic [DATA_W-1:0]       o_ir,
    output logic [ADDR_W-1:0]       o_pc,
    input  logic                    i_take,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_halted
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] ir_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] fetch_pc;
    logic              has_head;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              byp;

    assign has_head = (count != '0);
    assign mem_req  = (state == RUN) & (count < FULL)
                    & ~redirect & ~rst;
    assign mem_adr  = fetch_pc;
    assign push     = mem_req & mem_rdy;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = push & ~has_head;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word taken in the same cycle never enters storage.
    assign o_rdy = has_head | byp;
    assign pop   = has_head & i_take;
    assign wr_en = push & ~(byp & i_take);

    always_comb begin
        o_ir = '0;
        o_pc = '0;
        if (has_head) begin
            o_ir = ir_mem[rd_ptr];
            o_pc = pc_mem[rd_ptr];
        end else if (byp) begin
            o_ir = mem_data;
            o_pc = fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= redirect_adr;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push)
                fetch_pc <= fetch_pc + ADDR_W'(1);
            if (wr_en && !pop)
                count <= count + CW'(1);
            else if (!wr_en && pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ir_mem[wr_ptr] <= mem_data;
            pc_mem[wr_ptr] <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (halt)
                    state_nxt = HALTED;
            end
            HALTED: begin
                if (resume && !halt)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign o_count  = count;
    assign o_halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue
// against a queue-based reference model.
module tb_fetch_queue;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] RPC = 16'h0100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_rdy = 1'b0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_req;
    logic [AW-1:0] mem_adr;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_adr = '0;
    logic          halt = 1'b0;
    logic          resume = 1'b0;
    logic          o_rdy;
    logic [DW-1:0] o_ir;
    logic [AW-1:0] o_pc;
    logic          i_take = 1'b0;
    logic [CW-1:0] o_count;
    logic          o_halted;

    int tests = 0;
    int fails = 0;

    fetch_queue #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_rdy(mem_rdy), .mem_data(mem_data),
        .mem_req(mem_req), .mem_adr(mem_adr),
        .redirect(redirect), .redirect_adr(redirect_adr),
        .halt(halt), .resume(resume),
        .o_rdy(o_rdy), .o_ir(o_ir), .o_pc(o_pc),
        .i_take(i_take), .o_count(o_count), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    // reference model: a queue of fetched words plus fetch PC and halt flag
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] ir;
    } ent_t;

    ent_t          q[$];
    logic [AW-1:0] fpc = RPC;
    bit            halted = 1'b0;

    function automatic bit m_req();
        return !halted && q.size() < DEPTH && !redirect && !rst;
    endfunction

    function automatic bit m_byp();
`ifdef FETCH_QUEUE_BYPASS_EN
        return q.size() == 0 && m_req() && mem_rdy;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_rdy();
        return q.size() > 0 || m_byp();
    endfunction

    function automatic logic [DW-1:0] m_ir();
        if (q.size() > 0) return q[0].ir;
        if (m_byp()) return mem_data;
        return '0;
    endfunction

    function automatic logic [AW-1:0] m_pc();
        if (q.size() > 0) return q[0].pc;
        if (m_byp()) return fpc;
        return '0;
    endfunction

    task automatic m_update();
        int  sz;
        bit  push;
        bit  take;
        if (rst) begin
            q.delete();
            fpc = RPC;
            halted = 1'b0;
        end else begin
            sz = q.size();
            push = m_req() && mem_rdy;
            take = i_take && m_rdy();
            if (redirect) begin
                q.delete();
                fpc = redirect_adr;
            end else begin
                if (take && sz > 0)
                    void'(q.pop_front());
                if (push && !(take && sz == 0))
                    q.push_back('{pc: fpc, ir: mem_data});
                if (push)
                    fpc = fpc + 1'b1;
            end
            if (!halted && halt)
                halted = 1'b1;
            else if (halted && resume && !halt)
                halted = 1'b0;
        end
    endtask

    task automatic setin(input bit r, input logic [DW-1:0] d,
                         input bit t, input bit red,
                         input logic [AW-1:0] ra,
                         input bit h, input bit rs);
        @(negedge clk);
        mem_rdy = r;
        mem_data = d;
        i_take = t;
        redirect = red;
        redirect_adr = ra;
        halt = h;
        resume = rs;
        #1;
    endtask

    task automatic cyc();
        m_update();
        @(posedge clk);
        #1;
        mem_rdy = 1'b0;
        i_take = 1'b0;
        redirect = 1'b0;
        halt = 1'b0;
        resume = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setin(1, 16'h1111, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        tests++;
        if ({mem_req, o_rdy, o_halted} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000",
                     {mem_req, o_rdy, o_halted});
        end
        tests++;
        if ({mem_adr, o_ir, o_pc, o_count} !== {RPC, 32'h0, 3'd0}) begin
            fails++;
            $display("FAIL reset_vals adr=%h ir=%h pc=%h cnt=%0d",
                     mem_adr, o_ir, o_pc, o_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (mem_req !== 1'b1 || mem_adr !== RPC) begin
            fails++;
            $display("FAIL reset_release req=%b adr=%h want 1 %h",
                     mem_req, mem_adr, RPC);
        end
        cyc();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            setin(1, ~fpc, 0, 0, 0, 0, 0);
            if (i > 0) begin
                tests++;
                if (o_count !== CW'(i) || o_pc !== RPC) begin
                    fails++;
                    $display("FAIL fill_step%0d cnt=%0d pc=%h", i,
                             o_count, o_pc);
                end
            end
            cyc();
        end
        tests++;
        if (o_count !== 3'd4 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL fill_full cnt=%0d req=%b want 4 0",
                     o_count, mem_req);
        end
        tests++;
        if (o_pc !== 16'h0100 || o_ir !== 16'hFEFF) begin
            fails++;
            $display("FAIL fill_head pc=%h ir=%h want 0100 feff",
                     o_pc, o_ir);
        end
    endtask

    task automatic test_take_full();
        setin(1, ~fpc, 1, 0, 0, 0, 0);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL full_req got %b want 0", mem_req);
        end
        cyc();
        tests++;
        if (o_pc !== 16'h0101 || o_count !== 3'd3
            || mem_adr !== 16'h0104) begin
            fails++;
            $display("FAIL take_head pc=%h cnt=%0d adr=%h", o_pc,
                     o_count, mem_adr);
        end
        setin(1, ~fpc, 0, 0, 0, 0, 0);
        cyc();
        tests++;
        if (o_count !== 3'd4) begin
            fails++;
            $display("FAIL refill_cnt got %0d want 4", o_count);
        end
    endtask

    task automatic test_redirect();
        setin(0, 0, 1, 0, 0, 0, 0);
        cyc();
        setin(1, 16'hDEAD, 1, 1, 16'h2000, 0, 0);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL redir_req got %b want 0", mem_req);
        end
        cyc();
        tests++;
        if (o_count !== 3'd0 || o_rdy !== 1'b0
            || mem_adr !== 16'h2000) begin
            fails++;
            $display("FAIL redir_flush cnt=%0d rdy=%b adr=%h",
                     o_count, o_rdy, mem_adr);
        end
        setin(1, ~fpc, 0, 0, 0, 0, 0);
        cyc();
        tests++;
        if (o_pc !== 16'h2000 || o_ir !== 16'hDFFF
            || o_count !== 3'd1) begin
            fails++;
            $display("FAIL redir_first pc=%h ir=%h cnt=%0d", o_pc,
                     o_ir, o_count);
        end
    endtask

    task automatic test_halt_drain();
        setin(1, ~fpc, 0, 0, 0, 0, 0);
        cyc();
        setin(0, 0, 0, 0, 0, 1, 0);
        tests++;
        if (o_halted !== 1'b0 || mem_req !== 1'b1) begin
            fails++;
            $display("FAIL halt_same halted=%b req=%b want 0 1",
                     o_halted, mem_req);
        end
        cyc();
        tests++;
        if (o_halted !== 1'b1 || mem_req !== 1'b0
            || o_count !== 3'd2) begin
            fails++;
            $display("FAIL halt_state h=%b req=%b cnt=%0d",
                     o_halted, mem_req, o_count);
        end
        for (int i = 0; i < 2; i++) begin
            setin(1, 16'hBEEF, 1, 0, 0, 0, 0);
            tests++;
            if (o_pc !== AW'(16'h2000 + i)) begin
                fails++;
                $display("FAIL drain%0d pc=%h", i, o_pc);
            end
            cyc();
        end
        tests++;
        if (o_count !== 3'd0 || o_halted !== 1'b1) begin
            fails++;
            $display("FAIL drained cnt=%0d h=%b", o_count, o_halted);
        end
        setin(0, 0, 0, 0, 0, 0, 1);
        cyc();
        tests++;
        if (o_halted !== 1'b0 || mem_req !== 1'b1
            || mem_adr !== 16'h2002) begin
            fails++;
            $display("FAIL resume h=%b req=%b adr=%h", o_halted,
                     mem_req, mem_adr);
        end
    endtask

    task automatic test_wrap();
        setin(0, 0, 0, 1, 16'hFFFF, 0, 0);
        cyc();
        setin(1, 16'h5A5A, 0, 0, 0, 0, 0);
        cyc();
        tests++;
        if (mem_adr !== 16'h0000 || o_pc !== 16'hFFFF
            || o_ir !== 16'h5A5A) begin
            fails++;
            $display("FAIL wrap adr=%h pc=%h ir=%h", mem_adr, o_pc,
                     o_ir);
        end
        for (int i = 0; i < 2; i++) begin
            setin(0, 0, 0, 0, 0, 1, 1);
            cyc();
            tests++;
            if (o_halted !== 1'b1) begin
                fails++;
                $display("FAIL halt_wins%0d got %b want 1", i,
                         o_halted);
            end
        end
        setin(0, 0, 0, 0, 0, 0, 1);
        cyc();
    endtask

    task automatic test_bypass();
        setin(0, 0, 0, 1, 16'h3000, 0, 0);
        cyc();
        setin(1, 16'h1234, 1, 0, 0, 0, 0);
`ifdef FETCH_QUEUE_BYPASS_EN
        tests++;
        if (o_rdy !== 1'b1 || o_ir !== 16'h1234
            || o_pc !== 16'h3000) begin
            fails++;
            $display("FAIL bypass rdy=%b ir=%h pc=%h", o_rdy, o_ir,
                     o_pc);
        end
        cyc();
        tests++;
        if (o_count !== 3'd0) begin
            fails++;
            $display("FAIL bypass_cnt got %0d want 0", o_count);
        end
`else
        tests++;
        if (o_rdy !== 1'b0 || o_ir !== 16'h0000) begin
            fails++;
            $display("FAIL no_bypass rdy=%b ir=%h want 0", o_rdy,
                     o_ir);
        end
        cyc();
        tests++;
        if (o_count !== 3'd1 || o_pc !== 16'h3000) begin
            fails++;
            $display("FAIL no_bypass_cnt cnt=%0d pc=%h", o_count,
                     o_pc);
        end
`endif
    endtask

    task automatic test_random();
        logic [AW+DW+AW+CW+2:0] got;
        logic [AW+DW+AW+CW+2:0] exp;
        for (int i = 0; i < 400; i++) begin
            setin($urandom_range(0, 3) != 0, DW'($urandom),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, AW'($urandom),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            got = {mem_req, mem_adr, o_rdy, o_ir, o_pc, o_count,
                   o_halted};
            exp = {m_req(), fpc, m_rdy(), m_ir(), m_pc(),
                   CW'(q.size()), halted};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL random%0d got %h want %h", i, got, exp);
            end
            cyc();
            rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_take_full();
        test_redirect();
        test_halt_drain();
        test_wrap();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
